// File: rtl/comm_sched_pkg.sv
// Shared types and default timing constants for the comm channel frame schedulers.
package comm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRANS_GNT = 2'd1,
    TEST_GNT  = 2'd2
  } sched_state_e;

  localparam int FRAME_LEN_DEF  = 256;
  localparam int TRANS_SLOT_DEF = 128;
  localparam int TEST_SLOT_DEF  = 144;
  localparam int WIN_DEF        = 16;

endpackage

// File: rtl/frame_counter.sv
// Free-running wrapping frame position counter with run/hold control and a
// frame_start flag registered alongside the count.
module frame_counter #(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 8
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             frame_start
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             start_d, start_q;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      if (cnt_q == CNT_W'(FRAME_LEN - 1)) cnt_d = '0;
      else                                 cnt_d = cnt_q + CNT_W'(1);
    end
    // flag tracks the value the count is about to take
    start_d = enable && (cnt_d == '0);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign frame_cnt   = cnt_q;
  assign frame_start = start_q;

endmodule

// File: rtl/frame_slot_sched.sv
// Grants the shared comm channel to transmit then test at fixed frame slots,
// with done handshake, WIN-cycle forced release and test skip reporting.
//   state     | meaning
//   IDLE      | channel free, waiting for a slot with a pending request
//   TRANS_GNT | channel held by the transmit engine
//   TEST_GNT  | channel held by the test engine
module frame_slot_sched
  import comm_sched_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int CNT_W      = 8,
  parameter int TRANS_SLOT = TRANS_SLOT_DEF,
  parameter int TEST_SLOT  = TEST_SLOT_DEF,
  parameter int WIN        = WIN_DEF
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             trans_req,
  input  logic             test_req,
  input  logic             done,
  output logic             trans_grant,
  output logic             test_grant,
  output logic             frame_start,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             timeout,
  output logic             test_skip
);

  localparam int WIN_W = (WIN > 1) ? $clog2(WIN) : 1;

  sched_state_e     state_d, state_q;
  logic [WIN_W-1:0] win_d, win_q;
  logic             trans_pend_d, trans_pend_q;
  logic             test_pend_d, test_pend_q;
  logic             trans_grant_d, trans_grant_q;
  logic             test_grant_d, test_grant_q;
  logic             timeout_d, timeout_q;
  logic             test_skip_d, test_skip_q;
  logic             trans_hit, test_hit;

  frame_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_frame_counter (
    .sysclk      (sysclk),
    .reset       (reset),
    .enable      (enable),
    .frame_cnt   (frame_cnt),
    .frame_start (frame_start)
  );

  // a request in the slot cycle itself counts, so a 1-cycle pulse there is granted
  assign trans_hit = trans_pend_q || trans_req;
  assign test_hit  = test_pend_q  || test_req;

  always_comb begin
    state_d      = state_q;
    win_d        = '0;
    trans_pend_d = trans_hit;
    test_pend_d  = test_hit;
    timeout_d    = 1'b0;
    test_skip_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          if (frame_cnt == CNT_W'(TRANS_SLOT) && trans_hit) begin
            state_d      = TRANS_GNT;
            trans_pend_d = 1'b0;
          end else if (frame_cnt == CNT_W'(TEST_SLOT) && test_hit) begin
            state_d     = TEST_GNT;
            test_pend_d = 1'b0;
          end
        end
      end
      TRANS_GNT, TEST_GNT: begin
        // test keeps its pending flag and retries next frame
        if (state_q == TRANS_GNT && enable && frame_cnt == CNT_W'(TEST_SLOT) && test_hit)
          test_skip_d = 1'b1;
        if (!enable || done) begin
          state_d = IDLE;
        end else if (win_q == WIN_W'(WIN - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    trans_grant_d = (state_d == TRANS_GNT);
    test_grant_d  = (state_d == TEST_GNT);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      win_q         <= '0;
      trans_pend_q  <= 1'b0;
      test_pend_q   <= 1'b0;
      trans_grant_q <= 1'b0;
      test_grant_q  <= 1'b0;
      timeout_q     <= 1'b0;
      test_skip_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      trans_pend_q  <= trans_pend_d;
      test_pend_q   <= test_pend_d;
      trans_grant_q <= trans_grant_d;
      test_grant_q  <= test_grant_d;
      timeout_q     <= timeout_d;
      test_skip_q   <= test_skip_d;
    end
  end

  assign trans_grant = trans_grant_q;
  assign test_grant  = test_grant_q;
  assign timeout     = timeout_q;
  assign test_skip   = test_skip_q;

endmodule

// File: tb/tb_frame_slot_sched.sv
// Scoreboard bench for frame_slot_sched: stimulus queues expected grant/timeout/skip
// events, a negedge monitor collapses DUT outputs into events and compares.
module tb_frame_slot_sched;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b0;
  logic       trans_req = 1'b0;
  logic       test_req  = 1'b0;
  logic       done      = 1'b0;
  logic       trans_grant, test_grant, frame_start, timeout, test_skip;
  logic [7:0] frame_cnt;

  localparam int K_TRANS = 0, K_TEST = 1, K_TMO = 2, K_SKIP = 3;

  typedef struct {
    int kind;
    int cnt;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  frame_slot_sched dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .enable      (enable),
    .trans_req   (trans_req),
    .test_req    (test_req),
    .done        (done),
    .trans_grant (trans_grant),
    .test_grant  (test_grant),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt),
    .timeout     (timeout),
    .test_skip   (test_skip)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string kname(input int k);
    case (k)
      K_TRANS: return "trans_grant";
      K_TEST:  return "test_grant";
      K_TMO:   return "timeout";
      default: return "test_skip";
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic ev_t mk(input int k, input int c, input int l);
    ev_t e;
    e.kind = k; e.cnt = c; e.len = l;
    return e;
  endfunction

  task automatic check_event(input int kind, input int c, input int len);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got cnt=%0d len=%0d expected no event", kname(kind), c, len);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cnt != c || e.len != len) begin
        n_fail++;
        $display("FAIL event: got %s cnt=%0d len=%0d expected %s cnt=%0d len=%0d",
                 kname(kind), c, len, kname(e.kind), e.cnt, e.len);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic en_edge = 1'b0;
  always @(posedge sysclk) en_edge <= enable;

  int t_start, t_len, s_start, s_len, prev_cnt, exp_cnt;
  bit t_on = 0, s_on = 0, have_prev = 0;

  always @(negedge sysclk) begin
    if (!reset) begin
      t_on = 0; s_on = 0; have_prev = 0;
    end else begin
      if (have_prev) begin
        exp_cnt = en_edge ? ((prev_cnt == 255) ? 0 : prev_cnt + 1) : prev_cnt;
        chk("frame_cnt_step", int'(frame_cnt), exp_cnt);
        chk("frame_start", int'(frame_start), (en_edge && exp_cnt == 0) ? 1 : 0);
      end
      prev_cnt  = int'(frame_cnt);
      have_prev = 1;
      chk("grant_exclusive", int'(trans_grant && test_grant), 0);

      if (trans_grant) begin
        if (!t_on) begin t_on = 1; t_start = int'(frame_cnt); t_len = 0; end
        t_len++;
      end else if (t_on) begin
        t_on = 0;
        check_event(K_TRANS, t_start, t_len);
      end
      if (test_grant) begin
        if (!s_on) begin s_on = 1; s_start = int'(frame_cnt); s_len = 0; end
        s_len++;
      end else if (s_on) begin
        s_on = 0;
        check_event(K_TEST, s_start, s_len);
      end
      if (timeout)   check_event(K_TMO,  int'(frame_cnt), 0);
      if (test_skip) check_event(K_SKIP, int'(frame_cnt), 0);
    end
  end

  // ---------------- stimulus ----------------
  // Returns at the negedge inside the cycle where frame_cnt==v; inputs driven
  // there are sampled at the following posedge.
  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    @(negedge sysclk);
    while (int'(frame_cnt) != v && n < 2000) begin
      @(negedge sysclk);
      n++;
    end
    if (int'(frame_cnt) != v) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_cnt: got frame_cnt=%0d expected %0d within 2000 cycles", frame_cnt, v);
    end
  endtask

  task automatic pulse_trans();
    trans_req = 1'b1; @(negedge sysclk); trans_req = 1'b0;
  endtask
  task automatic pulse_test();
    test_req = 1'b1; @(negedge sysclk); test_req = 1'b0;
  endtask
  task automatic pulse_done();
    done = 1'b1; @(negedge sysclk); done = 1'b0;
  endtask

  initial begin
    int starts;

    // reset state
    repeat (3) @(negedge sysclk);
    chk("rst_frame_cnt",   int'(frame_cnt),   0);
    chk("rst_trans_grant", int'(trans_grant), 0);
    chk("rst_test_grant",  int'(test_grant),  0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_timeout",     int'(timeout),     0);
    chk("rst_test_skip",   int'(test_skip),   0);
    #2 reset = 1'b1;

    // idle run: no requests, 600 cycles, two wraps through 0
    @(negedge sysclk);
    enable = 1'b1;
    starts = 0;
    repeat (600) begin
      @(negedge sysclk);
      if (frame_start) starts++;
    end
    chk("idle_frame_starts", starts, 2);
    chk("idle_frame_cnt", int'(frame_cnt), 88);
    chk("idle_no_events", exp_q.size(), 0);

    // transmit request with done: grant 129..136
    exp_q.push_back(mk(K_TRANS, 129, 8));
    wait_cnt(10);  pulse_trans();
    wait_cnt(136); pulse_done();
    wait_cnt(200);
    chk("trans_done_drained", exp_q.size(), 0);

    // test request never done: full window then timeout
    exp_q.push_back(mk(K_TEST, 145, 16));
    exp_q.push_back(mk(K_TMO, 161, 0));
    wait_cnt(50); pulse_test();
    wait_cnt(200);
    chk("test_timeout_drained", exp_q.size(), 0);

    // both requests: transmit times out, test skipped, test granted next frame
    exp_q.push_back(mk(K_TRANS, 129, 16));
    exp_q.push_back(mk(K_TMO, 145, 0));
    exp_q.push_back(mk(K_SKIP, 145, 0));
    exp_q.push_back(mk(K_TEST, 145, 6));
    wait_cnt(20);
    trans_req = 1'b1; test_req = 1'b1;
    @(negedge sysclk);
    trans_req = 1'b0; test_req = 1'b0;
    wait_cnt(200);
    wait_cnt(150); pulse_done();
    wait_cnt(200);
    chk("skip_retry_drained", exp_q.size(), 0);

    // enable dropped mid-grant; test request accumulates while frozen
    exp_q.push_back(mk(K_TRANS, 129, 4));
    exp_q.push_back(mk(K_TEST, 145, 3));
    wait_cnt(10); pulse_trans();
    wait_cnt(132);
    enable = 1'b0;
    @(negedge sysclk);
    pulse_test();
    repeat (15) @(negedge sysclk);
    chk("frozen_frame_cnt", int'(frame_cnt), 132);
    chk("frozen_trans_grant", int'(trans_grant), 0);
    enable = 1'b1;
    @(negedge sysclk);
    chk("resume_frame_cnt", int'(frame_cnt), 133);
    wait_cnt(147); pulse_done();
    wait_cnt(200);
    wait_cnt(200);
    chk("disable_drained", exp_q.size(), 0);

    // async reset in the middle of a transmit grant
    wait_cnt(10); pulse_trans();
    wait_cnt(140);
    chk("pre_reset_trans_grant", int'(trans_grant), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_trans_grant", int'(trans_grant), 0);
    chk("arst_test_grant",  int'(test_grant),  0);
    chk("arst_frame_cnt",   int'(frame_cnt),   0);
    chk("arst_frame_start", int'(frame_start), 0);
    chk("arst_timeout",     int'(timeout),     0);
    chk("arst_test_skip",   int'(test_skip),   0);
    @(negedge sysclk);
    @(negedge sysclk);
    #2 reset = 1'b1;
    @(negedge sysclk);
    chk("post_reset_frame_cnt", int'(frame_cnt), 1);
    wait_cnt(200);
    wait_cnt(200);
    chk("post_reset_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
